alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_seq_if.sv | 28 ++
 rtl/mdu_iter.sv | 131 +++++++++++++
 rtl/alu_seq.sv | 116 +++++++++++
 tb/tb_alu_seq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared op-code, FSM state and width definitions for the sequential ALU.
// Divider support is selected with the ALU_SEQ_DIV_EN macro in the consuming files.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRA    = 5'd6,
        OP_SRL    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHSU = 5'd12,
        OP_MULHU  = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } alu_state_e;

    function automatic logic op_is_div(input logic [4:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bus of the sequential ALU.
// Both channels use valid/ready: a beat transfers on a rising clk edge where valid
// and ready are both high; valid and its payload stay stable until that edge.
interface alu_seq_if
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, illegal
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply (radix-2 shift-add) and, with ALU_SEQ_DIV_EN, restoring divide.
// Runs exactly XLEN steps after start; 'last' flags the final step and 'res' is valid with it.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last,
    output logic [XLEN-1:0] res
);
    localparam int CW = $clog2(XLEN);

    logic              busy_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   acc_q, lo_q, opnd_q;
    logic [XLEN-1:0]   acc_n, lo_n;
    logic              neg_q, hi_sel_q;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] prod;
`ifdef ALU_SEQ_DIV_EN
    logic              div_q, rem_sel_q, neg_rem_q;
    logic [XLEN:0]     shifted, trial;
    logic [XLEN-1:0]   quo, rem;
`endif

    // Operands are iterated as magnitudes; the sign is reapplied on the final step.
    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        case (op)
            OP_MUL, OP_MULH: begin
                a_neg = a[XLEN-1];
                b_neg = b[XLEN-1];
            end
            OP_MULHSU: a_neg = a[XLEN-1];
`ifdef ALU_SEQ_DIV_EN
            OP_DIV, OP_REM: begin
                a_neg = a[XLEN-1];
                b_neg = b[XLEN-1];
            end
`endif
            default: ;
        endcase
    end

    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;
    assign last  = busy_q && (cnt_q == CW'(XLEN - 1));

    always_comb begin
        sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        acc_n = sum[XLEN:1];
        lo_n  = {sum[0], lo_q[XLEN-1:1]};
        prod  = {acc_n, lo_n};
        if (neg_q) begin
            prod = ~prod + 1'b1;
        end
        res = hi_sel_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
`ifdef ALU_SEQ_DIV_EN
        shifted = {acc_q, lo_q[XLEN-1]};
        trial   = shifted - {1'b0, opnd_q};
        quo     = '0;
        rem     = '0;
        if (div_q) begin
            if (!trial[XLEN]) begin
                acc_n = trial[XLEN-1:0];
                lo_n  = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                acc_n = shifted[XLEN-1:0];
                lo_n  = {lo_q[XLEN-2:0], 1'b0};
            end
            quo = neg_q ? (~lo_n + 1'b1) : lo_n;
            rem = neg_rem_q ? (~acc_n + 1'b1) : acc_n;
            res = rem_sel_q ? rem : quo;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            hi_sel_q  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_q     <= 1'b0;
            rem_sel_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            neg_q    <= a_neg ^ b_neg;
            hi_sel_q <= (op != OP_MUL);
`ifdef ALU_SEQ_DIV_EN
            div_q     <= op_is_div(op);
            rem_sel_q <= (op == OP_REM) || (op == OP_REMU);
            neg_rem_q <= a_neg;
            if (op_is_div(op)) begin
                opnd_q <= b_mag;
                lo_q   <= a_mag;
            end else begin
                opnd_q <= a_mag;
                lo_q   <= b_mag;
            end
`else
            opnd_q <= a_mag;
            lo_q   <= b_mag;
`endif
        end else if (busy_q) begin
            acc_q <= acc_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                busy_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle integer ops plus iterative multiply/divide via mdu_iter.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise DIV/DIVU/REM/REMU report illegal.
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus,
    output alu_state_e dbg_state
);
    localparam int SHW = $clog2(XLEN);
`ifdef ALU_SEQ_DIV_EN
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
`endif

    alu_state_e      state_q, state_d, accept_state;
    logic [XLEN-1:0] result_q, quick_res, mdu_res;
    logic            illegal_q, quick_ill;
    logic            in_xfer, mdu_start, mdu_last;
    logic [SHW-1:0]  shamt;

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.illegal   = illegal_q;
    assign dbg_state     = state_q;

    assign in_xfer   = bus.in_valid && bus.in_ready;
    assign mdu_start = in_xfer && (accept_state != DONE);
    assign shamt     = bus.b[SHW-1:0];

    // Decode of the offered request: single-cycle result, or which iterative state to enter.
    always_comb begin
        quick_res    = '0;
        quick_ill    = 1'b0;
        accept_state = DONE;
        case (bus.op)
            OP_ADD:  quick_res = bus.a + bus.b;
            OP_SUB:  quick_res = bus.a - bus.b;
            OP_SLL:  quick_res = bus.a << shamt;
            OP_SLT:  quick_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: quick_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            OP_XOR:  quick_res = bus.a ^ bus.b;
            OP_SRA:  quick_res = $signed(bus.a) >>> shamt;
            OP_SRL:  quick_res = bus.a >> shamt;
            OP_OR:   quick_res = bus.a | bus.b;
            OP_AND:  quick_res = bus.a & bus.b;
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: accept_state = MUL;
`ifdef ALU_SEQ_DIV_EN
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                if (bus.b == '0) begin
                    quick_res = ((bus.op == OP_DIV) || (bus.op == OP_DIVU)) ? '1 : bus.a;
                end else if (((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                             (bus.a == MOST_NEG) && (bus.b == '1)) begin
                    quick_res = (bus.op == OP_DIV) ? bus.a : '0;
                end else begin
                    accept_state = DIV;
                end
            end
`endif
            default: quick_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_xfer) state_d = accept_state;
            end
            MUL, DIV: begin
                if (mdu_last) state_d = DONE;
            end
            DONE: begin
                if (in_xfer) begin
                    state_d = accept_state;
                end else if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_xfer && (accept_state == DONE)) begin
                result_q  <= quick_res;
                illegal_q <= quick_ill;
            end else if (mdu_last) begin
                result_q  <= mdu_res;
                illegal_q <= 1'b0;
            end
        end
    end

    mdu_iter #(
        .XLEN (XLEN)
    ) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mdu_start),
        .op    (bus.op),
        .a     (bus.a),
        .b     (bus.b),
        .last  (mdu_last),
        .res   (mdu_res)
    );
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at XLEN=32: single-cycle ops, multiply, divide or its
// illegal fallback, backpressure with back-to-back acceptance, and reset mid-iteration.
module tb_alu_seq;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    alu_state_e dbg_state;
    int         checks;
    int         failures;
    logic [31:0] exp_q[$];

    alu_seq_if #(.XLEN(32)) bus ();

    alu_seq #(
        .XLEN (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure cycles to out_valid, check, then let it drain.
    task automatic run_op(input string tag, input logic [4:0] op_v, input logic [31:0] a_v,
                          input logic [31:0] b_v, input int lat, input logic [31:0] res,
                          input logic ill);
        int n;
        exp_q.push_back(res);
        bus.in_valid = 1'b1;
        bus.op       = op_v;
        bus.a        = a_v;
        bus.b        = b_v;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        step();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 100) begin
            step();
            n++;
        end
        check($sformatf("%s_lat", tag), 64'(n), 64'(lat));
        check($sformatf("%s_res", tag), 64'(bus.result), 64'(exp_q.pop_front()));
        check($sformatf("%s_ill", tag), 64'(bus.illegal), 64'(ill));
        step();
    endtask

    initial begin
        int  n;
        logic seen;
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.op       = '0;
        bus.a        = '0;
        bus.b        = '0;
        bus.out_ready = 1'b1;
        repeat (3) step();

        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_illegal", 64'(bus.illegal), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        rst_n = 1'b1;
        step();

        run_op("sub",  OP_SUB,  32'd5, 32'd7, 1, 32'hFFFF_FFFE, 1'b0);
        run_op("add",  OP_ADD,  32'hFFFF_FFFF, 32'd2, 1, 32'd1, 1'b0);
        run_op("sll",  OP_SLL,  32'd1, 32'd35, 1, 32'd8, 1'b0);
        run_op("slt",  OP_SLT,  32'hFFFF_FFFF, 32'd1, 1, 32'd1, 1'b0);
        run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1'b0);
        run_op("xor",  OP_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 1, 32'hFF00_EDCB, 1'b0);
        run_op("sra",  OP_SRA,  32'h8000_0000, 32'd4, 1, 32'hF800_0000, 1'b0);
        run_op("srl",  OP_SRL,  32'h8000_0000, 32'd4, 1, 32'h0800_0000, 1'b0);
        run_op("or",   OP_OR,   32'hA000_0005, 32'h0500_000A, 1, 32'hA500_000F, 1'b0);
        run_op("and",  OP_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 1, 32'h0F00_0F00, 1'b0);

        run_op("mulh_min",  OP_MULH,   32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 1'b0);
        run_op("mul_min",   OP_MUL,    32'h8000_0000, 32'h8000_0000, 33, 32'h0000_0000, 1'b0);
        run_op("mul_neg",   OP_MUL,    32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFEB, 1'b0);
        run_op("mulhu_max", OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 1'b0);
        run_op("mulhsu",    OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 33, 32'hFFFF_FFFF, 1'b0);

`ifdef ALU_SEQ_DIV_EN
        run_op("div_neg",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_neg",  OP_REM,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 1'b0);
        run_op("divu",     OP_DIVU, 32'd100, 32'd7, 33, 32'd14, 1'b0);
        run_op("remu",     OP_REMU, 32'd100, 32'd7, 33, 32'd2, 1'b0);
        run_op("divu_z",   OP_DIVU, 32'd7, 32'd0, 1, 32'hFFFF_FFFF, 1'b0);
        run_op("remu_z",   OP_REMU, 32'd7, 32'd0, 1, 32'd7, 1'b0);
        run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b0);
        run_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 1'b0);
`else
        run_op("div_off",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 1, 32'd0, 1'b1);
        run_op("divu_off", OP_DIVU, 32'd7, 32'd0, 1, 32'd0, 1'b1);
        run_op("rem_off",  OP_REM,  32'hFFFF_FFF9, 32'd2, 1, 32'd0, 1'b1);
        run_op("remu_off", OP_REMU, 32'd100, 32'd7, 1, 32'd0, 1'b1);
`endif
        run_op("op20",  5'd20, 32'd1, 32'd2, 1, 32'd0, 1'b1);
        run_op("op31",  5'd31, 32'd9, 32'd9, 1, 32'd0, 1'b1);

        // Backpressure: result must hold while out_ready is low, then overlap with a new ADD.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op        = OP_MUL;
        bus.a         = 32'd6;
        bus.b         = 32'd7;
        step();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 100) begin
            step();
            n++;
        end
        check("bp_lat", 64'(n), 64'd33);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_res", 64'(bus.result), 64'd42);
            check("bp_hold_rdy", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b1;
        bus.op        = OP_ADD;
        bus.a         = 32'd1;
        bus.b         = 32'd1;
        bus.out_ready = 1'b1;
        #1;
        check("bp_b2b_rdy", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        check("bp_b2b_valid", 64'(bus.out_valid), 64'd1);
        check("bp_b2b_res", 64'(bus.result), 64'd2);
        check("bp_b2b_ill", 64'(bus.illegal), 64'd0);
        step();
        check("bp_idle", 64'(dbg_state), 64'(IDLE));

        // Reset during the tenth iteration of an iterative op must discard it.
        bus.in_valid = 1'b1;
`ifdef ALU_SEQ_DIV_EN
        bus.op = OP_DIVU;
`else
        bus.op = OP_MULHU;
`endif
        bus.a = 32'hFFFF_FFFF;
        bus.b = 32'd3;
        step();
        bus.in_valid = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        step();
        check("abort_valid", 64'(bus.out_valid), 64'd0);
        check("abort_rdy", 64'(bus.in_ready), 64'd1);
        check("abort_res", 64'(bus.result), 64'd0);
        check("abort_state", 64'(dbg_state), 64'(IDLE));
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            step();
            if (bus.out_valid) seen = 1'b1;
        end
        check("abort_no_stale", 64'(seen), 64'd0);
        run_op("post_rst_add", OP_ADD, 32'd3, 32'd4, 1, 32'd7, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
